sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/arm_mem_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/sram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared encodings and address defaults for the SRAM port arbiter.
// Holds the FSM state type, grant codes and the saturating counter helper.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_D    = 2'b01;
    localparam logic [1:0] GRANT_I    = 2'b10;

    localparam logic [31:0] D_BASE_DEFAULT = 32'd1024;
    localparam logic [31:0] I_BASE_DEFAULT = 32'd0;
    localparam logic [15:0] CONFLICT_MAX   = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic [15:0] limit);
        return (value >= limit) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-served pointer and one-hot grant.
// Requester 0 is the data port and requester 1 the fetch port.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       contended
);

    // 1 while requester 1 was served last; reset value lets requester 0 win first.
    logic last_hi;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = last_hi ? 2'b01 : 2'b10;
        else if (req[0])
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end

    assign contended = &req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_hi <= 1'b1;
        else if (accept && (gnt != 2'b00))
            last_hi <= gnt[1];
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller between a data port and a read-only fetch port.
// state     | meaning
// ST_IDLE   | nothing in flight; arbitrate pending requests, enables low
// ST_BUSY_D | data port owns the controller until m_ready
// ST_BUSY_I | fetch port owns the controller until m_ready
module sram_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] D_BASE       = D_BASE_DEFAULT,
    parameter logic [31:0] I_BASE       = I_BASE_DEFAULT,
    parameter logic [15:0] CONFLICT_SAT = CONFLICT_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_rd_en,
    input  logic        d_wr_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    input  logic        i_rd_en,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        m_rd_en,
    output logic        m_wr_en,
    output logic [31:0] m_address,
    output logic [31:0] m_write_data,
    input  logic        m_ready,
    input  logic [31:0] m_read_data,
    output logic [1:0]  grant,
    output logic [15:0] conflict_cnt
);

    arb_state_t  state;
    arb_state_t  state_next;
    logic [1:0]  rr_gnt;
    logic        rr_contended;
    logic        d_req;
    logic        d_wr_q;
    logic        d_rd_done;
    logic        i_rd_done;
    logic [31:0] d_rdata_q;
    logic [31:0] i_rdata_q;

    assign d_req = d_rd_en | d_wr_en;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       ({i_rd_en, d_req}),
        .accept    (state == ST_IDLE),
        .gnt       (rr_gnt),
        .contended (rr_contended)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (rr_gnt[0])
                    state_next = ST_BUSY_D;
                else if (rr_gnt[1])
                    state_next = ST_BUSY_I;
            end
            ST_BUSY_D, ST_BUSY_I: begin
                if (m_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // If the data port lets go mid-access, d_wr_q keeps the access type alive until m_ready.
    always_comb begin
        m_rd_en      = 1'b0;
        m_wr_en      = 1'b0;
        m_address    = 32'd0;
        m_write_data = 32'd0;
        case (state)
            ST_BUSY_D: begin
                m_wr_en      = d_req ? d_wr_en : d_wr_q;
                m_rd_en      = d_req ? (d_rd_en & ~d_wr_en) : ~d_wr_q;
                m_address    = d_addr - D_BASE;
                m_write_data = d_wdata;
            end
            ST_BUSY_I: begin
                m_rd_en   = 1'b1;
                m_address = i_addr - I_BASE;
            end
            default: ;
        endcase
    end

    assign d_rd_done = (state == ST_BUSY_D) & m_ready & d_rd_en & ~d_wr_en;
    assign i_rd_done = (state == ST_BUSY_I) & m_ready & i_rd_en;
    assign d_ready   = ~d_req | ((state == ST_BUSY_D) & m_ready);
    assign i_ready   = ~i_rd_en | ((state == ST_BUSY_I) & m_ready);
    assign d_rdata   = d_rd_done ? m_read_data : d_rdata_q;
    assign i_rdata   = i_rd_done ? m_read_data : i_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant        <= GRANT_NONE;
            conflict_cnt <= 16'd0;
            d_rdata_q    <= 32'd0;
            i_rdata_q    <= 32'd0;
            d_wr_q       <= 1'b0;
        end else begin
            case (state_next)
                ST_BUSY_D: grant <= GRANT_D;
                ST_BUSY_I: grant <= GRANT_I;
                default:   grant <= GRANT_NONE;
            endcase
            if ((state == ST_IDLE) && rr_contended)
                conflict_cnt <= sat_inc16(conflict_cnt, CONFLICT_SAT);
            if (d_rd_done)
                d_rdata_q <= m_read_data;
            if (i_rd_done)
                i_rdata_q <= m_read_data;
            if (d_req)
                d_wr_q <= d_wr_en;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios, then random two-port traffic
// checked against a port-level reference model; a second instance has a low counter ceiling.
module tb_sram_port_arbiter;

    localparam logic [31:0] DB  = 32'd1024;
    localparam logic [15:0] SAT = 16'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_rd_en, d_wr_en, i_rd_en, m_ready;
    logic [31:0] d_addr, d_wdata, i_addr, m_read_data;
    logic        d_ready, i_ready, m_rd_en, m_wr_en;
    logic [31:0] d_rdata, i_rdata, m_address, m_write_data;
    logic [1:0]  grant;
    logic [15:0] conflict_cnt;

    logic        s_d_ready, s_i_ready, s_m_rd_en, s_m_wr_en;
    logic [31:0] s_d_rdata, s_i_rdata, s_m_address, s_m_write_data;
    logic [1:0]  s_grant;
    logic [15:0] s_conflict_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sram [64];
    int          mem_cnt;
    int          mem_lat;
    logic        mem_en;
    bit          rand_lat;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .i_rd_en(i_rd_en), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_address(m_address), .m_write_data(m_write_data),
        .m_ready(m_ready), .m_read_data(m_read_data),
        .grant(grant), .conflict_cnt(conflict_cnt)
    );

    sram_port_arbiter #(.CONFLICT_SAT(SAT)) dut_sat (
        .clk(clk), .rst(rst),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(s_d_ready), .d_rdata(s_d_rdata),
        .i_rd_en(i_rd_en), .i_addr(i_addr), .i_ready(s_i_ready), .i_rdata(s_i_rdata),
        .m_rd_en(s_m_rd_en), .m_wr_en(s_m_wr_en), .m_address(s_m_address), .m_write_data(s_m_write_data),
        .m_ready(m_ready), .m_read_data(m_read_data),
        .grant(s_grant), .conflict_cnt(s_conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Controller model: m_ready rises on the mem_lat-th consecutive enabled cycle.
    task automatic respond();
        #1;
        mem_en = m_rd_en | m_wr_en;
        if (mem_en && (mem_cnt + 1 >= mem_lat)) begin
            m_ready     = 1'b1;
            m_read_data = m_rd_en ? sram[m_address[7:2]] : $urandom();
        end else begin
            m_ready     = 1'b0;
            m_read_data = $urandom();
        end
        @(negedge clk);
    endtask

    task automatic next_cycle();
        if (mem_en) begin
            if (m_ready) begin
                if (m_wr_en) sram[m_address[7:2]] = m_write_data;
                mem_cnt = 0;
                if (rand_lat) mem_lat = $urandom_range(1, 3);
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        m_ready = 1'b0; mem_en = 1'b0; mem_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_until_d_ready(input string tag);
        int n = 0;
        while (d_ready !== 1'b1 && n < 20) begin
            next_cycle();
            respond();
            n++;
        end
        chk({tag, "_timeout"}, 32'(d_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lowc;
        int          served;
        int          own, last, exp_conf;
        bit          d_act, i_act, d_is_wr, d_both, d_fin, i_fin, d_done, i_done;
        int          dk, ik;
        logic [31:0] d_wv, exp_d, exp_i, exp_g, exp_a, exp_w;
        logic [31:0] ref_mem [16];
        logic        exp_rd, exp_wr;

        rst = 1'b0;
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; i_addr = 32'd0;
        m_ready = 1'b0; m_read_data = 32'd0;
        mem_cnt = 0; mem_lat = 1; mem_en = 1'b0; rand_lat = 1'b0;
        for (int n = 0; n < 64; n++) sram[n] = 32'd0;

        // Reset values
        @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_m_rd_en", 32'(m_rd_en), 32'd0);
        chk("rst_m_wr_en", 32'(m_wr_en), 32'd0);
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single data read, 4-cycle controller
        mem_lat = 4;
        sram[1] = 32'h1234_5678;
        d_rd_en = 1'b1; d_addr = 32'd1028;
        respond();
        chk("t038_idle_grant", 32'(grant), 32'd0);
        chk("t038_idle_rd_en", 32'(m_rd_en), 32'd0);
        lowc = 0;
        while (d_ready !== 1'b1 && lowc < 12) begin
            lowc++;
            next_cycle();
            respond();
            if (d_ready !== 1'b1) begin
                chk("t038_busy_addr", m_address, 32'd4);
                chk("t038_busy_rd_en", 32'(m_rd_en), 32'd1);
            end
        end
        chk("t038_low_cycles", lowc, 32'd4);
        chk("t038_rdata", d_rdata, 32'h1234_5678);
        chk("t038_grant", 32'(grant), 32'd1);
        next_cycle();
        d_rd_en = 1'b0;
        respond();
        chk("t038_after_grant", 32'(grant), 32'd0);
        chk("t038_after_hold", d_rdata, 32'h1234_5678);

        // Simultaneous requests from reset
        do_reset();
        mem_lat = 1;
        sram[2] = 32'h0000_BEEF;
        d_rd_en = 1'b1; d_addr = 32'd1028;
        i_rd_en = 1'b1; i_addr = 32'd8;
        respond();
        chk("t039_t0_grant", 32'(grant), 32'd0);
        chk("t039_t0_conflict", 32'(conflict_cnt), 32'd0);
        chk("t039_t0_i_ready", 32'(i_ready), 32'd0);
        next_cycle();
        respond();
        chk("t039_t1_grant", 32'(grant), 32'd1);
        chk("t039_t1_d_ready", 32'(d_ready), 32'd1);
        chk("t039_t1_i_ready", 32'(i_ready), 32'd0);
        chk("t039_t1_conflict", 32'(conflict_cnt), 32'd1);
        chk("t039_t1_d_rdata", d_rdata, 32'h1234_5678);
        next_cycle();
        d_rd_en = 1'b0;
        respond();
        chk("t039_t2_grant", 32'(grant), 32'd0);
        chk("t039_t2_rd_en", 32'(m_rd_en), 32'd0);
        next_cycle();
        respond();
        chk("t039_t3_grant", 32'(grant), 32'd2);
        chk("t039_t3_addr", m_address, 32'd8);
        chk("t039_t3_i_ready", 32'(i_ready), 32'd1);
        chk("t039_t3_i_rdata", i_rdata, 32'h0000_BEEF);
        chk("t039_t3_conflict", 32'(conflict_cnt), 32'd1);
        next_cycle();
        i_rd_en = 1'b0;
        respond();

        // Both ports requesting continuously: strict alternation
        do_reset();
        mem_lat = 1;
        d_rd_en = 1'b1; d_addr = 32'd1028;
        i_rd_en = 1'b1; i_addr = 32'd8;
        respond();
        served = 0;
        for (int n = 0; n < 40 && served < 6; n++) begin
            next_cycle();
            respond();
            if (m_ready) begin
                chk("t040_order", 32'(grant), (served % 2 == 0) ? 32'd1 : 32'd2);
                served++;
            end
        end
        chk("t040_served", served, 32'd6);
        chk("t040_conflict", 32'(conflict_cnt), 32'd6);
        chk("t040_sat_conflict", 32'(s_conflict_cnt), 32'(SAT));
        next_cycle();
        d_rd_en = 1'b0; i_rd_en = 1'b0;
        respond();
        next_cycle();
        respond();
        chk("t040_conflict_hold", 32'(conflict_cnt), 32'd6);

        // Read and write together: write wins, d_rdata untouched
        mem_lat = 2;
        d_rd_en = 1'b1; d_wr_en = 1'b1; d_addr = 32'd1036; d_wdata = 32'hCAFE_F00D;
        respond();
        next_cycle();
        respond();
        chk("t041_wr_en", 32'(m_wr_en), 32'd1);
        chk("t041_rd_en", 32'(m_rd_en), 32'd0);
        chk("t041_wdata", m_write_data, 32'hCAFE_F00D);
        chk("t041_addr", m_address, 32'd12);
        chk("t041_busy_ready", 32'(d_ready), 32'd0);
        next_cycle();
        respond();
        chk("t041_done_ready", 32'(d_ready), 32'd1);
        chk("t041_rdata_kept", d_rdata, 32'h1234_5678);
        next_cycle();
        d_rd_en = 1'b0; d_wr_en = 1'b0;
        respond();
        next_cycle();
        d_rd_en = 1'b1;
        respond();
        run_until_d_ready("t041_rb");
        chk("t041_readback", d_rdata, 32'hCAFE_F00D);
        next_cycle();
        d_rd_en = 1'b0;
        respond();

        // Reset in the middle of a fetch access
        sram[4] = 32'hA5A5_0004;
        mem_lat = 10;
        i_rd_en = 1'b1; i_addr = 32'd16;
        respond();
        next_cycle();
        respond();
        chk("t042_busy_grant", 32'(grant), 32'd2);
        chk("t042_busy_rd_en", 32'(m_rd_en), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t042_rst_rd_en", 32'(m_rd_en), 32'd0);
        chk("t042_rst_wr_en", 32'(m_wr_en), 32'd0);
        chk("t042_rst_grant", 32'(grant), 32'd0);
        chk("t042_rst_conflict", 32'(conflict_cnt), 32'd0);
        chk("t042_rst_i_rdata", i_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_cnt = 0; mem_en = 1'b0; mem_lat = 1;
        respond();
        chk("t042_rel_grant", 32'(grant), 32'd0);
        next_cycle();
        respond();
        chk("t042_serve_grant", 32'(grant), 32'd2);
        chk("t042_serve_addr", m_address, 32'd16);
        chk("t042_serve_ready", 32'(i_ready), 32'd1);
        chk("t042_serve_rdata", i_rdata, 32'hA5A5_0004);
        next_cycle();
        i_rd_en = 1'b0;
        respond();

        // Owner drops its request mid-access
        mem_lat = 3;
        d_rd_en = 1'b1; d_addr = 32'd1028;
        respond();
        next_cycle();
        respond();
        next_cycle();
        d_rd_en = 1'b0;
        respond();
        chk("drop_rd_en", 32'(m_rd_en), 32'd1);
        chk("drop_grant", 32'(grant), 32'd1);
        chk("drop_ready", 32'(d_ready), 32'd1);
        next_cycle();
        respond();
        chk("drop_done_ready", 32'(m_ready), 32'd1);
        chk("drop_done_rd_en", 32'(m_rd_en), 32'd1);
        chk("drop_rdata_kept", d_rdata, 32'd0);
        next_cycle();
        respond();
        chk("drop_idle_grant", 32'(grant), 32'd0);
        chk("drop_idle_rd_en", 32'(m_rd_en), 32'd0);

        // Random traffic against the reference model
        do_reset();
        rand_lat = 1'b1;
        mem_lat = $urandom_range(1, 3);
        for (int n = 0; n < 16; n++) begin
            ref_mem[n] = $urandom();
            sram[n] = ref_mem[n];
        end
        own = -1; last = 1; exp_conf = 0; exp_d = 32'd0; exp_i = 32'd0;
        d_act = 0; i_act = 0; d_is_wr = 0; d_both = 0; d_fin = 0; i_fin = 0;
        dk = 0; ik = 0; d_wv = 32'd0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc != 0) next_cycle();
            if (d_fin) d_act = 0;
            if (i_fin) i_act = 0;
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1;
                d_is_wr = ($urandom_range(0, 2) == 0);
                d_both = ($urandom_range(0, 1) == 0);
                dk = $urandom_range(0, 15);
                d_wv = $urandom();
            end
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1;
                ik = $urandom_range(0, 15);
            end
            d_rd_en = d_act && (!d_is_wr || d_both);
            d_wr_en = d_act && d_is_wr;
            d_addr  = DB + 32'(dk * 4);
            d_wdata = d_wv;
            i_rd_en = i_act;
            i_addr  = 32'(ik * 4);
            respond();

            exp_g  = (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0;
            exp_rd = (own == 0) ? !d_is_wr : (own == 1);
            exp_wr = (own == 0) && d_is_wr;
            exp_a  = (own == 0) ? 32'(dk * 4) : 32'(ik * 4);
            exp_w  = (own == 0) ? d_wv : 32'd0;
            d_done = (own == 0) && m_ready;
            i_done = (own == 1) && m_ready;
            if (d_done && !d_is_wr) exp_d = ref_mem[dk];
            if (d_done && d_is_wr) ref_mem[dk] = d_wv;
            if (i_done) exp_i = ref_mem[ik];

            chk("rnd_grant", 32'(grant), exp_g);
            chk("rnd_grant_s", 32'(s_grant), exp_g);
            chk("rnd_m_rd_en", 32'(m_rd_en), 32'(exp_rd));
            chk("rnd_m_rd_en_s", 32'(s_m_rd_en), 32'(exp_rd));
            chk("rnd_m_wr_en", 32'(m_wr_en), 32'(exp_wr));
            chk("rnd_m_wr_en_s", 32'(s_m_wr_en), 32'(exp_wr));
            if (own >= 0) begin
                chk("rnd_m_address", m_address, exp_a);
                chk("rnd_m_address_s", s_m_address, exp_a);
                chk("rnd_m_wdata", m_write_data, exp_w);
                chk("rnd_m_wdata_s", s_m_write_data, exp_w);
            end
            chk("rnd_d_ready", 32'(d_ready), 32'(!d_act || d_done));
            chk("rnd_d_ready_s", 32'(s_d_ready), 32'(!d_act || d_done));
            chk("rnd_i_ready", 32'(i_ready), 32'(!i_act || i_done));
            chk("rnd_i_ready_s", 32'(s_i_ready), 32'(!i_act || i_done));
            chk("rnd_d_rdata", d_rdata, exp_d);
            chk("rnd_d_rdata_s", s_d_rdata, exp_d);
            chk("rnd_i_rdata", i_rdata, exp_i);
            chk("rnd_i_rdata_s", s_i_rdata, exp_i);
            chk("rnd_conflict", 32'(conflict_cnt), 32'(exp_conf));
            chk("rnd_conflict_sat", 32'(s_conflict_cnt), (exp_conf > int'(SAT)) ? 32'(SAT) : 32'(exp_conf));

            if (own < 0) begin
                if (d_act && i_act) begin
                    own = (last == 0) ? 1 : 0;
                    exp_conf++;
                end else if (d_act) begin
                    own = 0;
                end else if (i_act) begin
                    own = 1;
                end
                if (own >= 0) last = own;
            end else if (m_ready) begin
                own = -1;
            end
            d_fin = d_done;
            i_fin = i_done;
        end
        next_cycle();
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        respond();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
